// File: rtl/start_sequencer.sv
// start_sequencer: request FIFO feeding a start/done delay stage.
// Each queued hold length is replayed as a start level of that many cycles.
// The block then waits for the stage's done pulse, counts the completion,
// and idles for one gap cycle so the stage re-arms before the next request.
// Optional build macro: START_SEQ_WATCHDOG_EN adds a WAIT-state timeout that
// pulses err and abandons the transaction without counting it.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | start low; pops the FIFO head when one is available
// S_DRIVE | start high; len_cnt_q counts the remaining hold cycles
// S_WAIT  | start low; waiting for the stage's done pulse
// S_GAP   | start low for one cycle so the stage returns to idle

module start_sequencer #(
  parameter int N     = 3,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             req_valid_i,
  input  logic [N-1:0]     req_len_i,
  output logic             req_ready_o,
  output logic             start_o,
  input  logic             done_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] done_cnt_o,
  output logic             trunc_o,
  output logic             err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [N-1:0]     LEN_ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_GAP
  } state_t;

  logic [N-1:0]     mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic [N-1:0]     head;

  state_t           state_q;
  logic [N-1:0]     len_cnt_q;
  logic             start_q;
  logic             trunc_q;
  logic [CNT_W-1:0] done_cnt_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push       = req_valid_i && !fifo_full;
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  assign head       = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values from this cycle's push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // FIFO pointer registers; reset flushes any queued requests.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= req_len_i;
  end

`ifdef START_SEQ_WATCHDOG_EN
  // done must arrive within 2^N+2 WAIT cycles; the counter holds cycles already spent.
  localparam int              WD_LIMIT = (1 << N) + 2;
  localparam logic [N+1:0]    WD_LAST  = (N+2)'(WD_LIMIT - 1);
  logic [N+1:0]               wd_q;
  logic                       err_q;
`endif

  // Sequencing FSM with registered start, trunc, err and completion count.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      len_cnt_q  <= '0;
      start_q    <= 1'b0;
      trunc_q    <= 1'b0;
      done_cnt_q <= '0;
`ifdef START_SEQ_WATCHDOG_EN
      wd_q       <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      trunc_q <= 1'b0;
`ifdef START_SEQ_WATCHDOG_EN
      err_q   <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            len_cnt_q <= (head == '0) ? LEN_ONE : head;
            start_q   <= 1'b1;
            state_q   <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          // A done while still driving means the stage timed out first.
          if (done_i) begin
            start_q    <= 1'b0;
            trunc_q    <= 1'b1;
            done_cnt_q <= done_cnt_q + CNT_ONE;
            state_q    <= S_GAP;
          end else if (len_cnt_q == LEN_ONE) begin
            start_q <= 1'b0;
            state_q <= S_WAIT;
`ifdef START_SEQ_WATCHDOG_EN
            wd_q    <= '0;
`endif
          end else begin
            len_cnt_q <= len_cnt_q - 1'b1;
          end
        end
        S_WAIT: begin
          if (done_i) begin
            done_cnt_q <= done_cnt_q + CNT_ONE;
            state_q    <= S_GAP;
          end
`ifdef START_SEQ_WATCHDOG_EN
          else if (wd_q == WD_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_GAP;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
`endif
        end
        S_GAP: begin
          state_q <= S_IDLE;
        end
        default: begin
          start_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready_o = !fifo_full;
  assign start_o     = start_q;
  assign busy_o      = (state_q != S_IDLE) || !fifo_empty;
  assign done_cnt_o  = done_cnt_q;
  assign trunc_o     = trunc_q;
`ifdef START_SEQ_WATCHDOG_EN
  assign err_o       = err_q;
`else
  assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_start_sequencer.sv
// Bench for start_sequencer: a delay-stage stand-in answers start with done,
// a timeline model predicts every output cycle by cycle, and directed
// scenarios add hand-computed literal expectations.
module tb_start_sequencer;
  localparam int N     = 3;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int MAXC  = 4096;
  localparam int TOUT  = 7;     // stage timeout: 2^N-1 cycles of start high

  logic             clk = 1'b0;
  logic             reset_i = 1'b1;
  logic             req_valid_i = 1'b0;
  logic [N-1:0]     req_len_i = '0;
  logic             done_i = 1'b0;
  logic             req_ready_o;
  logic             start_o;
  logic             busy_o;
  logic [CNT_W-1:0] done_cnt_o;
  logic             trunc_o;
  logic             err_o;

  start_sequencer #(.N(N), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .reset_i(reset_i), .req_valid_i(req_valid_i),
    .req_len_i(req_len_i), .req_ready_o(req_ready_o), .start_o(start_o),
    .done_i(done_i), .busy_o(busy_o), .done_cnt_o(done_cnt_o),
    .trunc_o(trunc_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  // Delay-stage stand-in: done two cycles after start falls, or on the
  // TOUT-th cycle of start high if start is held that long.
  bit stage_en = 1'b1;
  bit s_prev = 1'b0;
  bit s_armed = 1'b0;
  int s_hi = 0;
  int s_fall = 0;
  always @(posedge clk) begin
    #1;
    done_i = 1'b0;
    if (s_fall > 0) begin
      s_fall--;
      if (s_fall == 0 && stage_en) done_i = 1'b1;
    end
    if (start_o === 1'b1) begin
      if (!s_prev) begin s_hi = 0; s_armed = 1'b1; end
      s_hi++;
      if (s_hi == TOUT && s_armed) begin
        if (stage_en) done_i = 1'b1;
        s_armed = 1'b0;
      end
      s_prev = 1'b1;
    end else begin
      if (s_prev && s_armed) s_fall = 2;
      s_armed = 1'b0;
      s_prev = 1'b0;
    end
  end

  // Timeline model: per-cycle expected outputs, indexed by cycle number
  // (cycle c is the interval following rising edge c).
  bit m_start [MAXC];
  bit m_trunc [MAXC];
  bit m_err   [MAXC];
  bit m_act   [MAXC];
  bit rst_at  [MAXC];
  int push_at [MAXC];
  int pop_at  [MAXC];
  int cnt_inc [MAXC];
  int occ_m = 0;
  int free_edge = 0;
  logic [CNT_W-1:0] cnt_m = '0;
  bit live = 1'b0;

  // A request accepted at edge c+1 is popped at the first edge where the
  // sequencer is idle, then plays out against the stage stand-in.
  task automatic sched(input int c, input int len);
    int lp, p, h;
    lp = (len == 0) ? 1 : len;
    p  = (c + 2 > free_edge) ? c + 2 : free_edge;
    h  = (lp >= TOUT) ? TOUT : lp;
    if (p + h + 14 >= MAXC) begin
      $display("FAIL model_range cycle=%0d actual=%0d expected<%0d", cyc, p, MAXC);
      $fatal(1, "model timeline exhausted");
    end
    push_at[c+1]++;
    pop_at[p]++;
    for (int j = 0; j < h; j++) m_start[p+j] = 1'b1;
    if (lp >= TOUT) begin
      m_trunc[p+TOUT] = 1'b1;
      cnt_inc[p+TOUT]++;
      for (int j = p; j <= p + TOUT; j++) m_act[j] = 1'b1;
      free_edge = p + TOUT + 2;
    end else if (stage_en) begin
      cnt_inc[p+h+3]++;
      for (int j = p; j <= p + h + 3; j++) m_act[j] = 1'b1;
      free_edge = p + h + 5;
    end else begin
      m_err[p+h+10] = 1'b1;
      for (int j = p; j <= p + h + 10; j++) m_act[j] = 1'b1;
      free_edge = p + h + 12;
    end
  endtask

  // Compare process: every cycle after the first reset edge.
  always @(negedge clk) begin
    int c;
    c = cyc;
    if (c >= MAXC - 20) begin
      $display("FAIL cycle_budget cycle=%0d actual=%0d expected<%0d", c, c, MAXC - 20);
      $fatal(1, "cycle budget exhausted");
    end
    if (rst_at[c]) begin live = 1'b1; occ_m = 0; cnt_m = '0; end
    occ_m = occ_m + push_at[c] - pop_at[c];
    cnt_m = cnt_m + CNT_W'(cnt_inc[c]);
    if (live) begin
      check("start", int'(start_o), int'(m_start[c]));
      check("trunc", int'(trunc_o), int'(m_trunc[c]));
      check("err", int'(err_o), int'(m_err[c]));
      check("busy", int'(busy_o), int'((occ_m > 0) || m_act[c]));
      check("req_ready", int'(req_ready_o), int'(occ_m < DEPTH));
      check("done_cnt", int'(done_cnt_o), int'(cnt_m));
    end
    if (reset_i) begin
      rst_at[c+1] = 1'b1;
      for (int j = c + 1; j < MAXC; j++) begin
        m_start[j] = 1'b0; m_trunc[j] = 1'b0; m_err[j] = 1'b0; m_act[j] = 1'b0;
        push_at[j] = 0; pop_at[j] = 0; cnt_inc[j] = 0;
      end
      free_edge = 0;
    end else if (req_valid_i && occ_m < DEPTH) begin
      sched(c, int'(req_len_i));
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run_count(input int n, output int hi, output int pulses,
                           output int trn, output int er, output int min_gap);
    bit prev;
    bit seen;
    int low;
    hi = 0; pulses = 0; trn = 0; er = 0; min_gap = 1000;
    prev = 1'b0; seen = 1'b0; low = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (start_o === 1'b1) begin
        hi++;
        if (!prev) begin
          pulses++;
          if (seen && low < min_gap) min_gap = low;
          seen = 1'b1;
        end
        low = 0;
        prev = 1'b1;
      end else begin
        low++;
        prev = 1'b0;
      end
      if (trunc_o === 1'b1) trn++;
      if (err_o === 1'b1) er++;
    end
  endtask

  task automatic push_n(input int count, input int len, input int budget,
                        output int pushed, output bit saw_full);
    int guard;
    bit rdy;
    pushed = 0; saw_full = 1'b0; guard = 0;
    req_len_i = N'(len);
    req_valid_i = 1'b1;
    while (pushed < count && guard < budget) begin
      rdy = req_ready_o;
      if (!rdy) saw_full = 1'b1;
      step(1);
      if (rdy) pushed++;
      guard++;
    end
    req_valid_i = 1'b0;
  endtask

  initial begin
    int hi, pulses, trn, er, mg, pushed;
    bit saw_full;

    // Reset
    reset_i = 1'b1;
    step(3);
    reset_i = 1'b0;
    check("rst_start", int'(start_o), 0);
    check("rst_ready", int'(req_ready_o), 1);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done_cnt", int'(done_cnt_o), 0);

    // Single request of length 3
    req_len_i = 3'd3; req_valid_i = 1'b1;
    step(1);
    req_valid_i = 1'b0;
    run_count(14, hi, pulses, trn, er, mg);
    check("t1_hi_cycles", hi, 3);
    check("t1_trunc", trn, 0);
    check("t1_done_cnt", int'(done_cnt_o), 1);
    check("t1_busy_end", int'(busy_o), 0);

    // Length 0 behaves as length 1
    req_len_i = 3'd0; req_valid_i = 1'b1;
    step(1);
    req_valid_i = 1'b0;
    run_count(12, hi, pulses, trn, er, mg);
    check("t2_hi_cycles", hi, 1);
    check("t2_done_cnt", int'(done_cnt_o), 2);

    // Fill the FIFO behind a running transaction
    req_len_i = 3'd2; req_valid_i = 1'b1;
    step(1);
    req_valid_i = 1'b0;
    step(2);
    push_n(5, 2, 100, pushed, saw_full);
    check("t3_pushes", pushed, 5);
    check("t3_ready_low_seen", int'(saw_full), 1);
    run_count(60, hi, pulses, trn, er, mg);
    check("t3_gap_ge2", int'(mg >= 2), 1);
    check("t3_done_cnt", int'(done_cnt_o), 8);
    check("t3_busy_end", int'(busy_o), 0);

    // Length 7 hits the stage timeout while start is high
    req_len_i = 3'd7; req_valid_i = 1'b1;
    step(1);
    req_valid_i = 1'b0;
    run_count(20, hi, pulses, trn, er, mg);
    check("t4_hi_cycles", hi, 7);
    check("t4_trunc_pulses", trn, 1);
    check("t4_done_cnt", int'(done_cnt_o), 9);

    // Reset during DRIVE with two entries queued
    req_len_i = 3'd5; req_valid_i = 1'b1;
    step(3);
    req_valid_i = 1'b0;
    check("t5_start_pre", int'(start_o), 1);
    reset_i = 1'b1;
    step(1);
    reset_i = 1'b0;
    check("t5_start", int'(start_o), 0);
    check("t5_busy", int'(busy_o), 0);
    check("t5_done_cnt", int'(done_cnt_o), 0);
    check("t5_ready", int'(req_ready_o), 1);
    run_count(20, hi, pulses, trn, er, mg);
    check("t5_no_pulses", pulses, 0);

    // Completion counter wraps: 257 completions from zero leave 1
    push_n(257, 1, 2500, pushed, saw_full);
    check("wrap_pushes", pushed, 257);
    run_count(40, hi, pulses, trn, er, mg);
    check("wrap_done_cnt", int'(done_cnt_o), 1);

`ifdef START_SEQ_WATCHDOG_EN
    // Watchdog: stage never answers
    reset_i = 1'b1;
    step(2);
    reset_i = 1'b0;
    stage_en = 1'b0;
    req_len_i = 3'd2; req_valid_i = 1'b1;
    step(1);
    req_valid_i = 1'b0;
    run_count(25, hi, pulses, trn, er, mg);
    check("wd_hi_cycles", hi, 2);
    check("wd_err_pulses", er, 1);
    check("wd_done_cnt", int'(done_cnt_o), 0);
    check("wd_busy_end", int'(busy_o), 0);
    stage_en = 1'b1;
`endif

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
